// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - pipelined AHB-Lite single-transfer master driven by a command/response stream
// Optional two-cycle ERROR handling and command cancellation: define AHB_MASTER_ERR_EN.
module ahb_lite_cmd_master #(
    parameter int WAIT_MAX = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timeout,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam int              CW       = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   WAIT_LIM = CW'(WAIT_MAX);
    localparam logic [1:0]      TR_IDLE   = 2'b00;
    localparam logic [1:0]      TR_NONSEQ = 2'b10;

    logic [31:0]   ap_wdata;
    logic          dp_valid;
    logic          dp_write;
    logic [CW-1:0] wait_cnt;
    logic          cancel_pending;
    logic          cmd_accept;

    assign HBURST     = 3'b000;
    assign cmd_ready  = HREADY && !cancel_pending;
    assign cmd_accept = cmd_valid && cmd_ready;

`ifdef AHB_MASTER_ERR_EN
    logic err_first;
    assign err_first = dp_valid && HRESP && !HREADY;
`else
    logic unused_hresp;
    assign unused_hresp   = HRESP;
    assign cancel_pending = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR     <= '0;
            HSIZE     <= '0;
            HTRANS    <= TR_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef AHB_MASTER_ERR_EN
            rsp_err        <= 1'b0;
            cancel_pending <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef AHB_MASTER_ERR_EN
            rsp_err   <= 1'b0;
`endif
            // Wait counter saturates at the limit so it cannot wrap and re-fire.
            if (dp_valid && !HREADY) begin
                if (wait_cnt != WAIT_LIM)
                    wait_cnt <= wait_cnt + 1'b1;
                if (WAIT_MAX != 0 && wait_cnt == WAIT_LIM - 1'b1)
                    timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (HREADY) begin
                if (dp_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= dp_write ? 32'h0 : HRDATA;
`ifdef AHB_MASTER_ERR_EN
                    rsp_err   <= HRESP;
`endif
                end
                dp_valid <= (HTRANS == TR_NONSEQ);
                dp_write <= HWRITE;
                HWDATA   <= ap_wdata;
                if (cmd_accept) begin
                    HTRANS   <= TR_NONSEQ;
                    HADDR    <= cmd_addr;
                    HSIZE    <= cmd_size;
                    HWRITE   <= cmd_write;
                    ap_wdata <= cmd_wdata;
                end else begin
                    HTRANS <= TR_IDLE;
                end
            end

`ifdef AHB_MASTER_ERR_EN
            // First ERROR cycle: withdraw the pending address phase and owe it a response.
            if (err_first) begin
                HTRANS <= TR_IDLE;
                if (HTRANS == TR_NONSEQ)
                    cancel_pending <= 1'b1;
            end
            // Cancelled command answers once the failed transfer has reported.
            if (cancel_pending && !dp_valid) begin
                rsp_valid      <= 1'b1;
                rsp_rdata      <= 32'h0;
                rsp_err        <= 1'b1;
                cancel_pending <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - scoreboard bench for ahb_lite_cmd_master with a behavioural AHB-Lite slave
module tb_ahb_lite_cmd_master;
`ifdef AHB_MASTER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err, timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;

    ahb_lite_cmd_master #(.WAIT_MAX(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout(timeout),
        .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] mem [16];
    int          wait_next = 0;
    logic        err_next  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input bit push);
        bit done = 1'b0;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge HCLK);
            if (cmd_ready) begin
                done = 1'b1;
                if (push) sb_q.push_back('{rdata: exp_rd, err: exp_err});
            end
            @(posedge HCLK);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL send_accept: command 0x%0h never accepted, required acceptance within 20 cycles", addr);
        end
    endtask

    // Response monitor
    initial begin
        forever begin
            @(negedge HCLK);
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rsp_unexpected: got rsp_valid 1 rdata 0x%0h, required no response", rsp_rdata);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Behavioural slave: optional wait states and two-cycle ERROR on the next data phase
    initial begin
        logic [1:0]  s_trans;
        logic [31:0] s_addr, s_wdata, dp_addr;
        logic        s_write, s_ready, s_resp, dp_act, dp_wr, dp_err, estage;
        int          dp_waits, wcnt;
        dp_act = 1'b0; dp_wr = 1'b0; dp_err = 1'b0; estage = 1'b0;
        dp_addr = 0; dp_waits = 0; wcnt = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            s_trans = HTRANS; s_addr = HADDR; s_write = HWRITE;
            s_wdata = HWDATA; s_ready = HREADY; s_resp = HRESP;
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                dp_act = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
            end else begin
                if (s_ready) begin
                    if (dp_act && dp_wr && !s_resp) mem[dp_addr[3:0]] = s_wdata;
                    dp_act = (s_trans == 2'b10);
                    if (dp_act) begin
                        dp_addr = s_addr; dp_wr = s_write; dp_waits = wait_next;
                        dp_err = err_next; wait_next = 0; err_next = 1'b0;
                        wcnt = 0; estage = 1'b0;
                    end
                end
                HREADY = 1'b1; HRESP = 1'b0;
                if (dp_act) begin
                    HRDATA = dp_wr ? 32'h0 : mem[dp_addr[3:0]];
                    if (wcnt < dp_waits) begin
                        HREADY = 1'b0; wcnt++;
                    end else if (dp_err) begin
                        HRESP = 1'b1; HREADY = estage; estage = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at 20000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = 0; cmd_write = 1'b0;
        cmd_wdata = 0; cmd_size = 3'b010;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("hburst", 32'(HBURST), 32'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle(2);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);

        // Zero-wait back-to-back writes
        send(32'h2, 1'b1, 32'h2, 32'h0, 1'b0, 1'b1);
        chk("w2_htrans", 32'(HTRANS), 32'h2);
        chk("w2_haddr", HADDR, 32'h2);
        chk("w2_hsize", 32'(HSIZE), 32'h2);
        send(32'h4, 1'b1, 32'h4, 32'h0, 1'b0, 1'b1);
        chk("w4_htrans_b2b", 32'(HTRANS), 32'h2);
        chk("w4_haddr", HADDR, 32'h4);
        chk("w2_hwdata", HWDATA, 32'h2);
        chk("w4_hwrite", 32'(HWRITE), 32'h1);
        idle(1);
        chk("w4_hwdata", HWDATA, 32'h4);
        chk("after_w4_idle", 32'(HTRANS), 32'h0);
        idle(4);

        // Write then read back, checking 3-cycle latency
        send(32'h6, 1'b1, 32'h6, 32'h0, 1'b0, 1'b1);
        send(32'h6, 1'b0, 32'h0, 32'h6, 1'b0, 1'b1);
        @(negedge HCLK); chk("lat_cyc1", 32'(rsp_valid), 32'h0);
        @(negedge HCLK); chk("lat_wr_pulse", 32'(rsp_valid), 32'h1);
        @(negedge HCLK); chk("lat_rd_pulse", 32'(rsp_valid), 32'h1);
        idle(4);

        // Three wait states on a read with a second read pending
        wait_next = 3;
        send(32'h6, 1'b0, 32'h0, 32'h6, 1'b0, 1'b1);
        send(32'h2, 1'b0, 32'h0, 32'h2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("ws_htrans", 32'(HTRANS), 32'h2);
            chk("ws_haddr", HADDR, 32'h2);
            chk("ws_cmd_ready", 32'(cmd_ready), 32'h0);
            @(posedge HCLK); #1;
        end
        @(negedge HCLK);
        chk("ws_ready_back", 32'(cmd_ready), 32'h1);
        chk("ws_rsp_not_yet", 32'(rsp_valid), 32'h0);
        @(negedge HCLK);
        chk("ws_rsp_delayed", 32'(rsp_valid), 32'h1);
        chk("ws_no_timeout", 32'(timeout), 32'h0);
        idle(5);

        // Timeout with WAIT_MAX=4 and five low cycles
        wait_next = 5;
        send(32'h4, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1);
        repeat (4) @(posedge HCLK);
        @(negedge HCLK); chk("to_before", 32'(timeout), 32'h0);
        @(negedge HCLK); chk("to_set", 32'(timeout), 32'h1);
        repeat (3) @(negedge HCLK);
        chk("to_hready_back", 32'(HREADY), 32'h1);
        chk("to_sticky", 32'(timeout), 32'h1);
        idle(4);

        // ERROR on write 0x8 with read 0xC pending
        err_next = 1'b1;
        send(32'h8, 1'b1, 32'h8, 32'h0, ERR_EN, 1'b1);
        send(32'hC, 1'b0, 32'h0, 32'h0, ERR_EN, 1'b1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("err_htrans", 32'(HTRANS), ERR_EN ? 32'h0 : 32'h2);
        chk("err_cmd_ready", 32'(cmd_ready), ERR_EN ? 32'h0 : 32'h1);
        @(negedge HCLK);
        chk("err_pulse1", 32'(rsp_valid), 32'h1);
        chk("err_flag1", 32'(rsp_err), 32'(ERR_EN));
        chk("err_cmd_ready2", 32'(cmd_ready), ERR_EN ? 32'h0 : 32'h1);
        @(negedge HCLK);
        chk("err_pulse2", 32'(rsp_valid), 32'h1);
        chk("err_flag2", 32'(rsp_err), 32'(ERR_EN));
        chk("err_cmd_ready3", 32'(cmd_ready), 32'h1);
        @(negedge HCLK);
        chk("err_done", 32'(rsp_valid), 32'h0);
        idle(4);

        // Asynchronous reset in the middle of a waited data phase
        wait_next = 2;
        send(32'h2, 1'b1, 32'h77, 32'h0, 1'b0, 1'b0);
        idle(1);
        chk("pre_rst_hwdata", HWDATA, 32'h77);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", 32'(HTRANS), 32'h0);
        chk("arst_haddr", HADDR, 32'h0);
        chk("arst_hwdata", HWDATA, 32'h0);
        chk("arst_hwrite", 32'(HWRITE), 32'h0);
        chk("arst_hsize", 32'(HSIZE), 32'h0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_rsp_rdata", rsp_rdata, 32'h0);
        chk("arst_rsp_err", 32'(rsp_err), 32'h0);
        chk("arst_timeout", 32'(timeout), 32'h0);
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(8);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
